// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Frame FSM states, frame bit constants and the FIFO level width helper.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_e;

   localparam int   PS2_DATA_BITS = 8;
   localparam logic PS2_START     = 1'b0;
   localparam logic PS2_STOP      = 1'b1;

   // Width of a counter that holds 0..depth inclusive.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous show-ahead FIFO; head word visible on rdata_o, 0 when empty.
// Ports: clk, clrn, push_i/wdata_i, pop_i, rdata_o, full_o, empty_o, level_o.
module ps2_fifo
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int WIDTH      = 8
) (
   input  logic                            clk,
   input  logic                            clrn,
   input  logic                            push_i,
   input  logic                            pop_i,
   input  logic [WIDTH-1:0]                wdata_i,
   output logic [WIDTH-1:0]                rdata_o,
   output logic                            full_o,
   output logic                            empty_o,
   output logic [lvl_w(FIFO_DEPTH)-1:0]    level_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = lvl_w(FIFO_DEPTH);

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [LW-1:0]    cnt_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == LW'(FIFO_DEPTH));
   assign level_o = cnt_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_q];

   // A pop frees the slot in the same cycle, so a full FIFO still accepts.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync, deglitch, deframe, buffer in a FIFO.
// Ports: clk, clrn, ps2_clk, ps2_data, rd_en, err_clr -> data, ready, level, sticky flags.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic                         clk,
   input  logic                         clrn,
   input  logic                         ps2_clk,
   input  logic                         ps2_data,
   input  logic                         rd_en,
   input  logic                         err_clr,
   output logic [7:0]                   data,
   output logic                         ready,
   output logic [lvl_w(FIFO_DEPTH)-1:0] level,
   output logic                         overflow,
   output logic                         parity_err,
   output logic                         frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]    clk_s_q;
   logic [1:0]    dat_s_q;
   logic          filt_q;
   logic [FW-1:0] fcnt_q;
   logic          fall;
   logic          bit_in;

   ps2_state_e    state_q;
   logic [2:0]    bitcnt_q;
   logic [7:0]    shreg_q;
   logic          par_q;
   logic [TW-1:0] to_q;

   logic          stop_ev;
   logic          par_ok;
   logic          push;
   logic          timeout;
   logic          full;
   logic          empty;
   logic          ovf_q;
   logic          perr_q;
   logic          ferr_q;

   // Clock sync and filter idle high so reset never looks like a falling edge.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_s_q <= 2'b11;
         dat_s_q <= 2'b00;
         filt_q  <= 1'b1;
         fcnt_q  <= '0;
      end else begin
         clk_s_q <= {clk_s_q[0], ps2_clk};
         dat_s_q <= {dat_s_q[0], ps2_data};
         if (clk_s_q[1] == filt_q) begin
            fcnt_q <= '0;
         end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q <= ~filt_q;
            fcnt_q <= '0;
         end else begin
            fcnt_q <= fcnt_q + 1'b1;
         end
      end
   end

   // High in the cycle the filter commits a 1->0 flip.
   assign fall   = filt_q & ~clk_s_q[1] & (fcnt_q == FW'(FILTER_LEN - 1));
   assign bit_in = dat_s_q[1];

   assign stop_ev = fall & (state_q == STOP);
   assign par_ok  = ^{shreg_q, par_q};
   assign push    = stop_ev & (bit_in == PS2_STOP) & par_ok;
   assign timeout = (state_q != IDLE) & ~fall
                  & (to_q == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         shreg_q  <= '0;
         par_q    <= 1'b0;
         to_q     <= '0;
      end else if (fall) begin
         to_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (bit_in == PS2_START) begin
                  state_q  <= DATA;
                  bitcnt_q <= '0;
               end
            end
            DATA: begin
               shreg_q  <= {bit_in, shreg_q[7:1]};
               bitcnt_q <= bitcnt_q + 1'b1;
               if (bitcnt_q == 3'(PS2_DATA_BITS - 1)) state_q <= PARITY;
            end
            PARITY: begin
               par_q   <= bit_in;
               state_q <= STOP;
            end
            STOP: state_q <= IDLE;
         endcase
      end else if (state_q == IDLE) begin
         to_q <= '0;
      end else if (timeout) begin
         state_q <= IDLE;
         to_q    <= '0;
      end else begin
         to_q <= to_q + 1'b1;
      end
   end

   // Set wins over err_clr.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ovf_q  <= 1'b0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         ovf_q  <= (push & full & ~rd_en) | (ovf_q & ~err_clr);
         perr_q <= (stop_ev & ~par_ok) | (perr_q & ~err_clr);
         ferr_q <= (stop_ev & (bit_in != PS2_STOP)) | timeout
                 | (ferr_q & ~err_clr);
      end
   end

   ps2_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (PS2_DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .clrn    (clrn),
      .push_i  (push),
      .pop_i   (rd_en),
      .wdata_i (shreg_q),
      .rdata_o (data),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

   assign ready      = ~empty;
   assign overflow   = ovf_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo against a frame-level queue model.
// Drives PS/2 frames on ps2_clk/ps2_data and checks all outputs.
module tb_ps2_rx_fifo;

   localparam int DEPTH = 8;
   localparam int FLEN  = 4;
   localparam int TOC   = 5000;
   localparam int HALF  = 20;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd_en = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] data;
   logic       ready;
   logic [3:0] level;
   logic       overflow;
   logic       parity_err;
   logic       frame_err;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   bit m_ovf = 0;
   bit m_par = 0;
   bit m_frm = 0;

   ps2_rx_fifo #(
      .FIFO_DEPTH  (DEPTH),
      .FILTER_LEN  (FLEN),
      .TIMEOUT_CYC (TOC)
   ) dut (
      .clk        (clk),
      .clrn       (clrn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .rd_en      (rd_en),
      .err_clr    (err_clr),
      .data       (data),
      .ready      (ready),
      .level      (level),
      .overflow   (overflow),
      .parity_err (parity_err),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      logic [7:0] hd;
      hd = (q.size() > 0) ? q[0] : 8'h00;
      chk({tag, ".level"}, 32'(level), 32'(q.size()));
      chk({tag, ".ready"}, 32'(ready), 32'(q.size() > 0));
      chk({tag, ".data"}, 32'(data), 32'(hd));
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".perr"}, 32'(parity_err), 32'(m_par));
      chk({tag, ".ferr"}, 32'(frame_err), 32'(m_frm));
   endtask

   // Odd parity: data bits plus parity bit hold an odd number of ones.
   function automatic logic [10:0] frame(input logic [7:0] b,
                                         input bit bad_par, input bit stop);
      logic p;
      p = ~(^b) ^ bad_par;
      return {stop, p, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int nbits,
                            input bit pop_at_stop, input int glitch_bit);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         if (i == glitch_bit) begin
            repeat (HALF / 2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         ps2_clk = 1'b0;
         if (pop_at_stop && i == 10) begin
            // 2 sync stages + FLEN filter samples: push on the 6th edge.
            repeat (2 + FLEN - 1) @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            repeat (HALF - 2 - FLEN) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         ps2_clk = 1'b1;
      end
   endtask

   task automatic rx(input logic [7:0] b, input bit bad_par, input bit stop,
                     input bit pop_same, input int glitch_bit);
      send_bits(frame(b, bad_par, stop), 11, pop_same, glitch_bit);
      if (pop_same && q.size() > 0) void'(q.pop_front());
      if (bad_par) m_par = 1;
      if (!stop) m_frm = 1;
      if (!bad_par && stop) begin
         if (q.size() < DEPTH) q.push_back(b);
         else m_ovf = 1;
      end
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
   endtask

   task automatic clr_flags();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_ovf = 0;
      m_par = 0;
      m_frm = 0;
   endtask

   initial begin
      logic [7:0] rb;
      int r;
      repeat (3) @(negedge clk);
      chk_all("reset");
      clrn = 1'b1;
      repeat (2) @(negedge clk);

      rx(8'h1C, 0, 1, 0, -1);
      chk("t1.const", 32'(data), 32'h1C);
      chk_all("t1.push");
      pop_one();
      chk_all("t1.pop");

      rx(8'h1C, 1, 1, 0, -1);
      chk_all("t2.bad");
      clr_flags();
      chk_all("t2.clr");
      rx(8'hF0, 0, 1, 0, -1);
      chk_all("t2.f0");
      pop_one();

      for (int i = 1; i <= 9; i++) rx(8'(i), 0, 1, 0, -1);
      chk_all("t3.full");
      for (int i = 0; i < 8; i++) begin
         chk_all("t3.head");
         pop_one();
      end
      chk_all("t3.empty");
      clr_flags();

      for (int i = 1; i <= 8; i++) rx(8'(i), 0, 1, 0, -1);
      rx(8'h09, 0, 1, 1, -1);
      chk_all("t4.pp");
      for (int i = 0; i < 8; i++) begin
         pop_one();
         chk_all("t4.drain");
      end

      send_bits(frame(8'hA5, 0, 1), 4, 0, -1);
      repeat (TOC + 50) @(negedge clk);
      m_frm = 1;
      chk_all("t5.timeout");
      clr_flags();
      rx(8'h5A, 0, 1, 0, -1);
      chk_all("t5.after");
      pop_one();

      rx(8'h5A, 0, 1, 0, 4);
      chk_all("t6.glitch");
      rx(8'h33, 0, 1, 0, -1);
      rx(8'h1C, 1, 1, 0, -1);
      chk_all("t6.pre");
      send_bits(frame(8'hC3, 0, 1), 6, 0, -1);
      ps2_data = 1'b1;
      repeat (HALF / 2) @(negedge clk);
      clrn = 1'b0;
      #1;
      q.delete();
      m_ovf = 0;
      m_par = 0;
      m_frm = 0;
      chk_all("t6.rst");
      repeat (3) @(negedge clk);
      clrn = 1'b1;
      repeat (2) @(negedge clk);
      rx(8'h5A, 0, 1, 0, -1);
      chk_all("t6.after");
      pop_one();

      for (int n = 0; n < 24; n++) begin
         rb = 8'($urandom);
         r  = $urandom_range(0, 9);
         rx(rb, r == 0, r != 1, 0, -1);
         chk_all("rnd.rx");
         if ($urandom_range(0, 3) == 0) begin
            clr_flags();
            chk_all("rnd.clr");
         end
         r = $urandom_range(0, 2);
         for (int k = 0; k < r; k++) pop_one();
         chk_all("rnd.pop");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
